cla_32_4: RTL and testbench

Registered 32-bit unsigned adder built as a two-level carry-lookahead tree: eight 4-bit CLA groups whose group propagate/generate signals feed a second-level lookahead unit. It is the datapath adder for coursework-level integer units, taking two 32-bit operands and producing a registered 32-bit sum and carry-out. Carry-in is fixed at 0.

---
 rtl/cla_32_4.sv | 107 ++++++++++
 tb/tb_cla_32_4.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cla_32_4.sv
// Registered 32-bit unsigned adder built from a two-level carry-lookahead tree (8 x 4-bit groups).
// Define CLA_32_4_INPUT_BYPASS_EN to drop the operand registers (1-cycle latency instead of 2).
module cla_32_4 (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Sum,
    output logic        Cout
);

    // Internal carries c1..c3 of a 4-wide lookahead block, fully expanded from its carry-in.
    function automatic logic [2:0] lookahead3(input logic [3:0] p, input logic [3:0] g,
                                              input logic c);
        logic [2:0] c_out;
        c_out[0] = g[0] | (p[0] & c);
        c_out[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        c_out[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        return c_out;
    endfunction

    // Block propagate/generate as {P, G}; same form at the group and super-block levels.
    function automatic logic [1:0] block_pg(input logic [3:0] p, input logic [3:0] g);
        logic bp;
        logic bg;
        bp = &p;
        bg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {bp, bg};
    endfunction

    logic [31:0] a_q;
    logic [31:0] b_q;

`ifdef CLA_32_4_INPUT_BYPASS_EN
    assign a_q = A;
    assign b_q = B;
`else
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= A;
            b_q <= B;
        end
    end
`endif

    logic [31:0] p;
    logic [31:0] g;
    logic [31:0] c;
    logic [7:0]  gp;
    logic [7:0]  gg;
    logic [1:0]  sp;
    logic [1:0]  sg;
    logic [1:0]  sc;
    logic [8:0]  gc;
    logic [31:0] sum_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        p     = a_q ^ b_q;
        g     = a_q & b_q;
        c     = '0;
        gp    = '0;
        gg    = '0;
        sp    = '0;
        sg    = '0;
        sc    = '0;
        gc    = '0;
        sum_d = '0;

        for (int k = 0; k < 8; k++)
            {gp[k], gg[k]} = block_pg(p[4*k +: 4], g[4*k +: 4]);
        for (int s = 0; s < 2; s++)
            {sp[s], sg[s]} = block_pg(gp[4*s +: 4], gg[4*s +: 4]);

        // Carry-in is fixed at 0, so the upper super-block's carry-in reduces to G* of the lower one.
        sc[0] = 1'b0;
        sc[1] = sg[0] | (sp[0] & sc[0]);
        gc[8] = sg[1] | (sp[1] & sg[0]);

        for (int s = 0; s < 2; s++) begin
            gc[4*s] = sc[s];
            gc[4*s+1 +: 3] = lookahead3(gp[4*s +: 4], gg[4*s +: 4], sc[s]);
        end

        for (int k = 0; k < 8; k++) begin
            c[4*k] = gc[k];
            c[4*k+1 +: 3] = lookahead3(p[4*k +: 4], g[4*k +: 4], gc[k]);
        end

        sum_d = p ^ c;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else begin
            Sum  <= sum_d;
            Cout <= gc[8];
        end
    end

endmodule

// File: tb/tb_cla_32_4.sv
// Directed self-checking bench for cla_32_4: reset hold, carry-chain vectors, pipelining, mid-flight reset.
module tb_cla_32_4;

`ifdef CLA_32_4_INPUT_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        c;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] Sum;
    logic        Cout;

    int checks = 0;
    int errors = 0;

    vec_t pipe_vecs[5];

    cla_32_4 dut (
        .clock (clock),
        .reset (reset),
        .A     (A),
        .B     (B),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] exp_sum, input logic exp_cout);
        checks++;
        assert ({Cout, Sum} === {exp_cout, exp_sum}) else begin
            errors++;
            $error("FAIL %s: got Cout=%b Sum=%h, want Cout=%b Sum=%h",
                   tag, Cout, Sum, exp_cout, exp_sum);
        end
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_sum, input logic exp_cout);
        @(negedge clock);
        A = a;
        B = b;
        repeat (LAT) @(posedge clock);
        #1;
        check(tag, exp_sum, exp_cout);
    endtask

    initial begin
        pipe_vecs[0] = '{32'h00FF_00FF, 32'hFF00_FF01, 32'h0000_0000, 1'b1};
        pipe_vecs[1] = '{32'h8080_8080, 32'h8080_8080, 32'h0101_0100, 1'b1};
        pipe_vecs[2] = '{32'h0000_00FF, 32'hFFFF_FF80, 32'h0000_007F, 1'b1};
        pipe_vecs[3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0};
        pipe_vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0};

        // Reset hold: outputs stay zero across edges and between them while operands are live.
        #1;
        reset = 1'b0;
        A = 32'h1234_5678;
        B = 32'h0000_0001;
        #1;
        check("rst_async", 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("rst_edge%0d", i), 32'h0, 1'b0);
            A = A + 32'h1111_0000;
            @(negedge clock);
            check($sformatf("rst_mid%0d", i), 32'h0, 1'b0);
        end
        reset = 1'b1;

        // Directed vectors, one at a time.
        run_vec("full_prop",   32'h00FF_00FF, 32'hFF00_FF01, 32'h0000_0000, 1'b1);
        run_vec("all_ones_p1", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        run_vec("grp_bound",   32'h8080_8080, 32'h8080_8080, 32'h0101_0100, 1'b1);
        run_vec("mixed_ff",    32'h0000_00FF, 32'hFFFF_FF80, 32'h0000_007F, 1'b1);
        run_vec("mixed_1_2",   32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0);
        run_vec("zeros",       32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        run_vec("max_max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        run_vec("msb_carry",   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
        run_vec("random_ish",  32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0);

        // Back-to-back operands, one new pair per cycle; results must emerge in order after LAT edges.
        for (int n = 0; n < 5 + LAT - 1; n++) begin
            @(negedge clock);
            if (n < 5) begin
                A = pipe_vecs[n].a;
                B = pipe_vecs[n].b;
            end
            @(posedge clock);
            #1;
            if (n + 1 >= LAT)
                check($sformatf("pipe%0d", n + 1 - LAT),
                      pipe_vecs[n + 1 - LAT].s, pipe_vecs[n + 1 - LAT].c);
        end

        // Reset pulse between sampling a pair and its output edge: that result must never appear.
        run_vec("pre_flush", 32'h8080_8080, 32'h8080_8080, 32'h0101_0100, 1'b1);
        @(negedge clock);
        A = 32'h1111_1111;
        B = 32'h2222_2222;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("flush_async", 32'h0, 1'b0);
        reset = 1'b1;
        #1;
        A = 32'h1234_5678;
        B = 32'h9ABC_DEF0;
        for (int i = 1; i < LAT; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("flushed%0d", i), 32'h0, 1'b0);
        end
        @(posedge clock);
        #1;
        check("post_flush", 32'hACF1_3568, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
